// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//   Multiply-accumulate engine for one neuron. A computation starts from a
//   signed bias, accepts N_INPUTS (activation, weight) pairs over a
//   valid/ready handshake, and adds each signed 32-bit product into a
//   saturating 32-bit accumulator. A one-cycle out_valid pulse marks the
//   final result.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   start        : begin a computation (only looked at in IDLE)
//   bias         : signed accumulator preload, captured on accepted start
//   in_valid     : an in_data/weight pair is present
//   in_ready     : block accepts a pair this cycle
//   in_data      : signed 16-bit activation
//   weight       : signed 16-bit weight
//   acc_out      : signed 32-bit accumulated result
//   out_valid    : one-cycle pulse, acc_out is final
//   busy         : high whenever the FSM is not in IDLE
//   overflow     : sticky saturation flag for the current neuron
//   dbg_state_o  : current FSM state, for observation only
//
// Handshake: a pair is transferred on every rising edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid; in_valid may be
// held low for any number of cycles (no timeout) and the pair count holds.
// -----------------------------------------------------------------------------
module neuron_mac #(
  parameter int N_INPUTS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] weight,
  output logic [31:0] acc_out,
  output logic        out_valid,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Count value held while the final pair is being accepted.
  localparam logic [7:0] LAST_IDX = 8'(N_INPUTS - 1);

  state_t             state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic signed [31:0] prod_q, prod_d;
  logic               prod_vld_q, prod_vld_d;
  logic [31:0]        acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic signed [31:0] product;
  logic [32:0]        sum33;

  // -32768 * -32768 = 0x40000000 still fits in 32 signed bits, so the
  // product never needs saturation; only the accumulation does.
  assign product = $signed(in_data) * $signed(weight);
  assign accept  = (state_q == S_ACCUM) && in_valid;
  assign sum33   = {acc_q[31], acc_q} + {prod_q[31], prod_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 8'd0;
      prod_q     <= 32'sd0;
      prod_vld_q <= 1'b0;
      acc_q      <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    ovf_d      = ovf_q;

    // Add the product registered on the previous accept. The two top bits
    // of the 33-bit sum disagree exactly when the result left 32-bit range;
    // bit 32 then tells which rail to clamp to.
    if (prod_vld_q) begin
      if (sum33[32] != sum33[31]) begin
        acc_d = sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum33[31:0];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = bias;
          count_d = 8'd0;
          ovf_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          prod_d     = product;
          prod_vld_d = 1'b1;
          count_d    = count_q + 8'd1;
          if (count_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end
      end
      // The last product is added on the edge leaving DRAIN.
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_ACCUM);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign acc_out     = acc_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] weight;
  logic [31:0] acc_out;
  logic        out_valid;
  logic        busy;
  logic        overflow;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  bit          exp_ovf_q[$];

  typedef struct {
    logic [31:0]          bias;
    logic [N-1:0][15:0]   d;
    logic [N-1:0][15:0]   w;
    int                   gap;        // max idle cycles before each pair
    bit                   hold_valid; // keep offering pairs after the last
    bit                   poke;       // pulse start mid-run
    logic [31:0]          exp_acc;
    bit                   exp_ovf;
  } vec_t;

  vec_t vecs[4];

  neuron_mac #(.N_INPUTS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bias        (bias),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .weight      (weight),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: start from bias, add each product in order, clamping to the
  // signed 32-bit range after every addition; any clamp sets overflow.
  function automatic void ref_model(input logic [31:0] b,
                                    input logic [N-1:0][15:0] d,
                                    input logic [N-1:0][15:0] w,
                                    output logic [31:0] acc,
                                    output bit ovf);
    longint a;
    a   = longint'($signed(b));
    ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      a = a + longint'($signed(d[i])) * longint'($signed(w[i]));
      if (a > 64'sd2147483647) begin
        a = 64'sd2147483647;
        ovf = 1'b1;
      end else if (a < -64'sd2147483648) begin
        a = -64'sd2147483648;
        ovf = 1'b1;
      end
    end
    acc = a[31:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        bit          eo;
        e  = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        chk("sb_acc_out", acc_out, e);
        chk("sb_overflow", {31'd0, overflow}, {31'd0, eo});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = $urandom;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_acc_eq_bias", acc_out, b);
    chk("start_ovf_clear", {31'd0, overflow}, 32'd0);
  endtask

  task automatic feed_pair(input logic [15:0] d, input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = d;
    weight   = w;
    chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    weight   = 16'($urandom);
  endtask

  // Full neuron run; entered and left in IDLE, #1 after an edge.
  task automatic run_vec(input vec_t v);
    do_start(v.bias);
    for (int i = 0; i < N; i++) begin
      int g;
      g = $urandom_range(0, v.gap);
      repeat (g) tick();
      if (v.poke && i == 2) begin
        start = 1'b1;
        bias  = 32'h1234_5678;
        tick();
        start = 1'b0;
      end
      feed_pair(v.d[i], v.w[i]);
    end
    // DRAIN cycle
    if (v.hold_valid) begin
      in_valid = 1'b1;
      in_data  = 16'd7;
      weight   = 16'd7;
    end
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(v.exp_acc);
    exp_ovf_q.push_back(v.exp_ovf);
    tick();
    // DONE cycle: two edges after the last accept
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_acc_hold", acc_out, v.exp_acc);
    chk("idle_ovf_hold", {31'd0, overflow}, {31'd0, v.exp_ovf});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    rst      = 1'b1;
    start    = 1'b0;
    bias     = 32'd0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    weight   = 16'd0;

    // Reset state
    repeat (2) tick();
    chk("rst_acc_out", acc_out, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors
    // positive saturation, further positive pairs stay clamped
    vecs[0].bias = 32'h7FFF_FF00;
    vecs[0].d[0] = 16'd16;  vecs[0].w[0] = 16'd16;
    vecs[0].d[1] = 16'd1;   vecs[0].w[1] = 16'd1;
    vecs[0].d[2] = 16'd100; vecs[0].w[2] = 16'd100;
    vecs[0].d[3] = 16'd2;   vecs[0].w[3] = 16'd2;
    vecs[0].gap = 1; vecs[0].hold_valid = 1'b0; vecs[0].poke = 1'b0;
    vecs[0].exp_acc = 32'h7FFF_FFFF; vecs[0].exp_ovf = 1'b1;
    // negative saturation
    vecs[1].bias = 32'h8000_0000;
    vecs[1].d[0] = 16'hFFFF; vecs[1].w[0] = 16'd1;
    vecs[1].d[1] = 16'd0;    vecs[1].w[1] = 16'd0;
    vecs[1].d[2] = 16'd0;    vecs[1].w[2] = 16'd0;
    vecs[1].d[3] = 16'd0;    vecs[1].w[3] = 16'd0;
    vecs[1].gap = 0; vecs[1].hold_valid = 1'b0; vecs[1].poke = 1'b0;
    vecs[1].exp_acc = 32'h8000_0000; vecs[1].exp_ovf = 1'b1;
    // 10 + 4*6 = 34, back-to-back, with a start pulse while busy
    vecs[2].bias = 32'd10;
    for (int i = 0; i < N; i++) begin
      vecs[2].d[i] = 16'd2;
      vecs[2].w[i] = 16'd3;
    end
    vecs[2].gap = 0; vecs[2].hold_valid = 1'b0; vecs[2].poke = 1'b1;
    vecs[2].exp_acc = 32'd34; vecs[2].exp_ovf = 1'b0;
    // -35 - 200 + 0x40000000 + 1 = 0x40000000 - 234 = 0x3FFFFF16
    vecs[3].bias = 32'd0;
    vecs[3].d[0] = 16'hFFFB; vecs[3].w[0] = 16'd7;
    vecs[3].d[1] = 16'd100;  vecs[3].w[1] = 16'hFFFE;
    vecs[3].d[2] = 16'h8000; vecs[3].w[2] = 16'h8000;
    vecs[3].d[3] = 16'd1;    vecs[3].w[3] = 16'd1;
    vecs[3].gap = 3; vecs[3].hold_valid = 1'b1; vecs[3].poke = 1'b0;
    vecs[3].exp_acc = 32'h3FFF_FF16; vecs[3].exp_ovf = 1'b0;

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // Reset asynchronously mid-computation
    do_start(32'd100);
    feed_pair(16'd1, 16'd1);
    feed_pair(16'd1, 16'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_acc_out", acc_out, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("arst_wait_start", {31'd0, busy}, 32'd0);
    end
    rv.bias = 32'd0;
    for (int i = 0; i < N; i++) begin
      rv.d[i] = 16'd1;
      rv.w[i] = 16'd1;
    end
    rv.gap = 1; rv.hold_valid = 1'b0; rv.poke = 1'b0;
    rv.exp_acc = 32'(N); rv.exp_ovf = 1'b0;
    run_vec(rv);

    // start held high: back-to-back neurons with one IDLE cycle between
    start = 1'b1;
    bias  = 32'd0;
    tick();
    for (int i = 0; i < N; i++) feed_pair(16'd2, 16'd2);
    exp_q.push_back(32'd16);
    exp_ovf_q.push_back(1'b0);
    tick();
    chk("held_done", {31'd0, out_valid}, 32'd1);
    bias = 32'd50;
    tick();
    chk("held_idle_gap", {31'd0, busy}, 32'd0);
    tick();
    chk("held_restart_busy", {31'd0, in_ready}, 32'd1);
    chk("held_restart_acc", acc_out, 32'd50);
    start = 1'b0;
    for (int i = 0; i < N; i++) feed_pair(16'd1, 16'd1);
    exp_q.push_back(32'd54);
    exp_ovf_q.push_back(1'b0);
    tick();
    chk("held2_done", {31'd0, out_valid}, 32'd1);
    tick();

    // Randomized runs against the reference model
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0: rv.bias = $urandom;
        1: rv.bias = 32'h7FF0_0000 + 32'($urandom_range(0, 32'hFFFFF));
        2: rv.bias = 32'h8000_0000 + 32'($urandom_range(0, 32'hFFFFF));
        default: rv.bias = 32'($urandom_range(0, 2000)) - 32'd1000;
      endcase
      for (int i = 0; i < N; i++) begin
        rv.d[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        rv.w[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      end
      rv.gap        = $urandom_range(0, 2);
      rv.hold_valid = 1'($urandom_range(0, 1));
      rv.poke       = 1'($urandom_range(0, 1));
      ref_model(rv.bias, rv.d, rv.w, rv.exp_acc, rv.exp_ovf);
      run_vec(rv);
    end

    repeat (3) tick();
    chk("sb_all_results_seen", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
